// File: rtl/pixel_loader.sv
// Streams grayscale pixels in, binarizes each against a threshold and packs
// eight results per byte (first pixel in the MSB) for a downstream classifier
// shift register. After the last byte of a frame the loader idles for
// SETTLE_CYCLES cycles, then pulses frame_done.
//
// Optional build macro: PIXEL_LOADER_INVERT_EN selects bit = (pix_data < threshold)
// for dark-on-light sources; the default is bit = (pix_data >= threshold).
module pixel_loader #(
  parameter int unsigned PIXELS        = 784,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_data,
  input  logic       pix_sof,
  input  logic [7:0] threshold,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       busy
);

  localparam int unsigned CntW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSettle,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] pix_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [6:0]      shift_q;
  logic [SetW-1:0] settle_cnt_q;
  logic            pix_ready_q;
  logic            wr_en_q;
  logic [7:0]      wr_data_q;
  logic            frame_done_q;
  logic            busy_q;

  logic hs;
  logic pix_bit;

  assign hs = pix_valid & pix_ready_q;

  // Binarize the incoming pixel (unsigned compare)
`ifdef PIXEL_LOADER_INVERT_EN
  assign pix_bit = (pix_data < threshold);
`else
  assign pix_bit = (pix_data >= threshold);
`endif

  // Frame FSM with counters, byte packing and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pix_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      settle_cnt_q <= '0;
      pix_ready_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          pix_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          // Pixels without sof are accepted and dropped
          if (hs && pix_sof) begin
            state_q   <= StLoad;
            busy_q    <= 1'b1;
            pix_cnt_q <= CntW'(1);
            bit_cnt_q <= 3'd1;
            shift_q   <= {6'b0, pix_bit};
          end
        end
        StLoad: begin
          if (hs) begin
            if (pix_sof) begin
              // Restart: this pixel is pixel 0, partial byte is dropped unwritten
              pix_cnt_q <= CntW'(1);
              bit_cnt_q <= 3'd1;
              shift_q   <= {6'b0, pix_bit};
            end else begin
              pix_cnt_q <= pix_cnt_q + CntW'(1);
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= {shift_q[5:0], pix_bit};
              if (bit_cnt_q == 3'd7) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= {shift_q, pix_bit};
              end
              // PIXELS is a multiple of 8, so the last pixel always closes a byte
              if (pix_cnt_q == CntW'(PIXELS - 1)) begin
                state_q      <= StSettle;
                pix_ready_q  <= 1'b0;
                pix_cnt_q    <= '0;
                settle_cnt_q <= '0;
              end
            end
          end
        end
        StSettle: begin
          // First SETTLE cycle carries the final wr_en; count the ones after it
          if (settle_cnt_q == SetW'(SETTLE_CYCLES)) begin
            state_q      <= StDone;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            settle_cnt_q <= settle_cnt_q + SetW'(1);
          end
        end
        StDone: begin
          state_q     <= StIdle;
          pix_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pix_ready  = pix_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pixel_loader.sv
// Directed bench for pixel_loader: full frames, packing patterns, discarded
// pre-sof pixels, mid-frame restart, valid gaps and mid-frame reset.
module tb_pixel_loader;

  localparam int unsigned PIXELS = 784;
  localparam int unsigned BYTES  = PIXELS / 8;

`ifdef PIXEL_LOADER_INVERT_EN
  localparam logic [7:0] ExpFf  = 8'h00;
  localparam logic [7:0] ExpAlt = 8'h55;
`else
  localparam logic [7:0] ExpFf  = 8'hFF;
  localparam logic [7:0] ExpAlt = 8'hAA;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic [7:0] threshold = 8'h80;
  logic       pix_ready;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       frame_done;
  logic       busy;

  int         n_tests = 0;
  int         n_fail = 0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] wr_q[$];

  pixel_loader #(
    .PIXELS       (PIXELS),
    .SETTLE_CYCLES(2)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .threshold (threshold),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Record every write strobe and frame_done pulse
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt = wr_cnt + 1;
      wr_q.push_back(wr_data);
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int kind, input int i);
    case (kind)
      0:       return 8'hFF;
      1:       return (i % 2 == 0) ? 8'h80 : 8'h7F;
      default: return 8'h00;
    endcase
  endfunction

  // Present one pixel and wait for its handshake; returns just after the edge
  task automatic push(input logic [7:0] d, input logic sof, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      @(negedge clk);
      pix_valid = 1'b0;
    end
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    while (!pix_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check_eq("ready_timeout", 32'(pix_ready), 32'd1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // Cycle-exact view of the final write, the settle window and frame_done
  task automatic tail(input logic [7:0] last);
    @(negedge clk);
    check_eq("tail_wr_en", 32'(wr_en), 32'd1);
    check_eq("tail_wr_data", 32'(wr_data), 32'(last));
    check_eq("tail_ready0", 32'(pix_ready), 32'd0);
    check_eq("tail_busy0", 32'(busy), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("settle_wr_en", 32'(wr_en), 32'd0);
      check_eq("settle_ready", 32'(pix_ready), 32'd0);
      check_eq("settle_busy", 32'(busy), 32'd1);
      check_eq("settle_done", 32'(frame_done), 32'd0);
    end
    @(negedge clk);
    check_eq("done_pulse", 32'(frame_done), 32'd1);
    check_eq("done_ready", 32'(pix_ready), 32'd0);
    check_eq("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("idle_done", 32'(frame_done), 32'd0);
    check_eq("idle_ready", 32'(pix_ready), 32'd1);
    check_eq("idle_wr_data_hold", 32'(wr_data), 32'(last));
  endtask

  task automatic run_frame(input string tag, input int kind, input bit gaps,
                           input logic [7:0] exp);
    int base, dbase, qb, bad;
    base  = wr_cnt;
    dbase = done_cnt;
    qb    = wr_q.size();
    for (int i = 0; i < int'(PIXELS); i++) begin
      push(pix_val(kind, i), (i == 0), gaps ? bit'($urandom_range(0, 1)) : 1'b0);
    end
    tail(exp);
    bad = 0;
    for (int j = qb; j < wr_q.size(); j++) if (wr_q[j] !== exp) bad++;
    check_eq({tag, "_writes"}, 32'(wr_cnt - base), 32'(BYTES));
    check_eq({tag, "_data_bad"}, 32'(bad), 32'd0);
    check_eq({tag, "_dones"}, 32'(done_cnt - dbase), 32'd1);
  endtask

  initial begin
    int base, dbase;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_ready", 32'(pix_ready), 32'd0);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", 32'(pix_ready), 32'd1);
    check_eq("rel_busy", 32'(busy), 32'd0);

    // All-white frame
    run_frame("ff", 0, 1'b0, ExpFf);

    // Alternating 0x80/0x7F against 0x80
    run_frame("alt", 1, 1'b0, ExpAlt);

    // Pixels without sof in IDLE are dropped
    base = wr_cnt;
    for (int i = 0; i < 5; i++) push(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("nosof_writes", 32'(wr_cnt - base), 32'd0);
    check_eq("nosof_busy", 32'(busy), 32'd0);
    run_frame("after_nosof", 0, 1'b0, ExpFf);

    // Restart at pixel 300: 37 writes, partial byte dropped, then a fresh frame
    base  = wr_cnt;
    dbase = done_cnt;
    for (int i = 0; i < 300; i++) push(8'h00, (i == 0), 1'b0);
    @(negedge clk);
    check_eq("restart_pre_writes", 32'(wr_cnt - base), 32'd37);
    check_eq("restart_pre_busy", 32'(busy), 32'd1);
    run_frame("restart", 0, 1'b0, ExpFf);
    check_eq("restart_total_writes", 32'(wr_cnt - base), 32'd135);
    check_eq("restart_total_dones", 32'(done_cnt - dbase), 32'd1);

    // Random valid gaps give the same byte sequence
    run_frame("gaps", 1, 1'b1, ExpAlt);

    // Reset at pixel 400, right while the 50th strobe is up
    base  = wr_cnt;
    dbase = done_cnt;
    for (int i = 0; i < 400; i++) push(8'hFF, (i == 0), 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_wr_en", 32'(wr_en), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ready", 32'(pix_ready), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("midrst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("midrst_writes", 32'(wr_cnt - base), 32'd49);
    check_eq("midrst_dones", 32'(done_cnt - dbase), 32'd0);
    check_eq("midrst_ready_back", 32'(pix_ready), 32'd1);
    run_frame("after_rst", 0, 1'b0, ExpFf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
